// File: rtl/bcd_timer_core.sv
// Up/down BCD stopwatch/timer: debounced buttons, run FSM, prescaled tick, registered 7-seg outputs.
// Optional lap display hold is built only when BCD_TIMER_LAP_EN is defined.
module bcd_timer_core #(
   parameter int NUM_DIGITS      = 4,
   parameter int CLK_HZ          = 10_000_000,
   parameter int TICK_HZ         = 100,
   parameter int DEBOUNCE_CYCLES = 100_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pb_start,
   input  logic                    pb_clear,
   input  logic                    mode_down,
   input  logic [4*NUM_DIGITS-1:0] preset,
   output logic [7*NUM_DIGITS-1:0] seg,
   output logic                    running,
   output logic                    time_done
);

   localparam int DW  = 4 * NUM_DIGITS;
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
   localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BCD_TIMER_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
      logic [DW-1:0] res;
      logic          carry;
      res   = v;
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) res[4*i +: 4] = 4'd0;
            else begin
               res[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
      logic [DW-1:0] res;
      logic          borrow;
      res    = v;
      borrow = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) res[4*i +: 4] = 4'd9;
            else begin
               res[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow        = 1'b0;
            end
         end
      end
      return res;
   endfunction

   function automatic logic [DW-1:0] bcd_sat(input logic [DW-1:0] v);
      logic [DW-1:0] res;
      res = v;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) res[4*i +: 4] = 4'd9;
      return res;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   // Button index 0 = start, 1 = clear.
   logic [1:0]    r_sync1, r_sync2, r_level, w_press;
   logic [CW-1:0] r_db_cnt [2];
   logic          w_start, w_clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_level <= '0;
         for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
      end else begin
         r_sync1 <= {pb_clear, pb_start};
         r_sync2 <= r_sync1;
         for (int b = 0; b < 2; b++) begin
            if (r_sync2[b] == r_level[b]) r_db_cnt[b] <= '0;
            else if (r_db_cnt[b] == DB_MAX) begin
               r_level[b]  <= r_sync2[b];
               r_db_cnt[b] <= '0;
            end else r_db_cnt[b] <= r_db_cnt[b] + CW'(1);
         end
      end
   end

   // Event fires in the cycle whose closing edge raises the debounced level.
   always_comb begin
      w_press = '0;
      for (int b = 0; b < 2; b++)
         w_press[b] = r_sync2[b] & ~r_level[b] & (r_db_cnt[b] == DB_MAX);
   end
   assign w_start = w_press[0];
   assign w_clear = w_press[1];

   state_t        r_state, w_state_nxt;
   logic [PW-1:0] r_presc;
   logic [DW-1:0] r_digits, w_next_val, w_load_val, w_disp;
   logic          r_mode_down, w_tick, w_load, w_count, w_mode_eff;

   assign w_tick     = (r_state == RUN) && (r_presc == PRESC_MAX);
   assign w_mode_eff = (r_state == IDLE) ? mode_down : r_mode_down;
   assign w_load_val = w_mode_eff ? bcd_sat(preset) : '0;
   assign w_next_val = !r_mode_down ? bcd_inc(r_digits) :
                       (r_digits == '0) ? '0 : bcd_dec(r_digits);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_count     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_clear)      w_load      = 1'b1;
            else if (w_start) w_state_nxt = RUN;
         end
         RUN: begin
            w_count = w_tick;
            if (w_tick && r_mode_down && (w_next_val == '0)) w_state_nxt = DONE;
            else if (w_start && !(LAP_EN && w_clear))        w_state_nxt = PAUSE;
         end
         PAUSE: begin
            if (w_clear) begin
               w_state_nxt = IDLE;
               w_load      = 1'b1;
            end else if (w_start) w_state_nxt = RUN;
         end
         DONE: begin
            if (w_clear) begin
               w_state_nxt = IDLE;
               w_load      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_digits    <= '0;
         r_presc     <= '0;
         r_mode_down <= 1'b0;
      end else begin
         if (w_load)       r_digits <= w_load_val;
         else if (w_count) r_digits <= w_next_val;
         // Mode follows the input while idle, so it freezes at the start press.
         if (r_state == IDLE) r_mode_down <= mode_down;
         if (w_state_nxt == IDLE)  r_presc <= '0;
         else if (r_state == RUN)  r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
      end
   end

`ifdef BCD_TIMER_LAP_EN
   logic          r_lap_hold, w_lap_tgl;
   logic [DW-1:0] r_lap;

   assign w_lap_tgl = (r_state == RUN) && w_clear && (w_state_nxt == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lap_hold <= 1'b0;
         r_lap      <= '0;
      end else if (w_state_nxt == IDLE || w_state_nxt == DONE) begin
         r_lap_hold <= 1'b0;
      end else if (w_lap_tgl) begin
         r_lap_hold <= ~r_lap_hold;
         if (!r_lap_hold) r_lap <= r_digits;
      end
   end

   assign w_disp = r_lap_hold ? r_lap : r_digits;
`else
   assign w_disp = r_digits;
`endif

   logic [7*NUM_DIGITS-1:0] r_seg, w_seg_nxt;

   always_comb begin
      w_seg_nxt = '0;
      for (int i = 0; i < NUM_DIGITS; i++) w_seg_nxt[7*i +: 7] = seg7(w_disp[4*i +: 4]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_seg <= {NUM_DIGITS{7'h3F}};
      else     r_seg <= w_seg_nxt;
   end

   assign seg       = r_seg;
   assign running   = (r_state == RUN);
   assign time_done = (r_state == DONE);

endmodule

// File: tb/tb_bcd_timer_core.sv
// Bench for bcd_timer_core: 4 digits, divide-by-10 tick, 3-cycle debounce.
// Expected display values come from elapsed run cycles / 10 and decimal arithmetic.
module tb_bcd_timer_core;

   localparam int ND = 4;
   localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pb_start = 1'b0;
   logic        pb_clear = 1'b0;
   logic        mode_down = 1'b0;
   logic [15:0] preset = '0;
   logic [27:0] seg;
   logic        running, time_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_timer_core #(
      .NUM_DIGITS(ND), .CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(3)
   ) dut (
      .clk(clk), .rst(rst), .pb_start(pb_start), .pb_clear(pb_clear),
      .mode_down(mode_down), .preset(preset), .seg(seg),
      .running(running), .time_done(time_done)
   );

   function automatic logic [27:0] seg_of(input int v);
      logic [27:0] res;
      int x;
      res = '0;
      x   = v;
      for (int i = 0; i < ND; i++) begin
         res[7*i +: 7] = SEG_TBL[x % 10];
         x = x / 10;
      end
      return res;
   endfunction

   function automatic int preset_value(input logic [15:0] p);
      int val, mult, nib;
      val  = 0;
      mult = 1;
      for (int i = 0; i < ND; i++) begin
         nib  = int'(p[4*i +: 4]);
         if (nib > 9) nib = 9;
         val  = val + nib * mult;
         mult = mult * 10;
      end
      return val;
   endfunction

   task automatic do_reset;
      rst = 1'b1; pb_start = 1'b0; pb_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Button pulse; the resulting state change lands on the 8th clock edge after the call.
   task automatic press(input logic s, input logic c);
      repeat (3) @(posedge clk);
      #1; pb_start = s; pb_clear = c;
      repeat (4) @(posedge clk);
      #1; pb_start = 1'b0; pb_clear = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      do_reset;
      checks++; if (seg !== seg_of(0)) begin errors++; $display("FAIL reset_seg: got %h want %h", seg, seg_of(0)); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
      checks++; if (time_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", time_done); end
   endtask

   task automatic test_debounce;
      int g;
      do_reset;
      g = $urandom_range(1, 2);
      @(posedge clk); #1 pb_start = 1'b1;
      repeat (g) @(posedge clk);
      #1 pb_start = 1'b0;
      repeat (12) @(posedge clk); #1;
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL debounce_glitch(%0d): running=%b want 0", g, running); end
      @(posedge clk); #1 pb_start = 1'b1;
      repeat (4) @(posedge clk); #1;
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL debounce_early: running=%b want 0", running); end
      @(posedge clk); #1;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL debounce_latency: running=%b want 1", running); end
      repeat (5) @(posedge clk); #1 pb_start = 1'b0;
      repeat (10) @(posedge clk); #1;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL debounce_single_event: running=%b want 1", running); end
   endtask

   task automatic test_count_up_pause;
      int r;
      do_reset;
      mode_down = 1'b0;
      r = $urandom_range(1, 9);
      press(1'b1, 1'b0);
      repeat (242 + r) @(posedge clk); #1;
      press(1'b1, 1'b0);
      checks++; if (seg !== seg_of(25)) begin errors++; $display("FAIL up_25: got %h want %h", seg, seg_of(25)); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b want 0", running); end
      repeat (100) @(posedge clk); #1;
      checks++; if (seg !== seg_of(25)) begin errors++; $display("FAIL pause_hold: got %h want %h", seg, seg_of(25)); end
      press(1'b1, 1'b0);
      repeat (10 - r) @(posedge clk); #1;
      checks++; if (seg !== seg_of(25)) begin errors++; $display("FAIL resume_early(r=%0d): got %h want %h", r, seg, seg_of(25)); end
      @(posedge clk); #1;
      checks++; if (seg !== seg_of(26)) begin errors++; $display("FAIL resume_26(r=%0d): got %h want %h", r, seg, seg_of(26)); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running: got %b want 1", running); end
   endtask

   task automatic test_random_runs;
      int run, w;
      for (int it = 0; it < 3; it++) begin
         do_reset;
         mode_down = 1'b0;
         run = 0;
         press(1'b1, 1'b0);
         for (int s = 0; s < 3; s++) begin
            w = $urandom_range(0, 40);
            repeat (w) @(posedge clk); #1;
            press(1'b1, 1'b0);
            run = run + w + 8;
            @(posedge clk); #1;
            checks++; if (seg !== seg_of((run / 10) % 10000)) begin errors++; $display("FAIL rand_run(%0d cycles): got %h want %h", run, seg, seg_of((run / 10) % 10000)); end
            checks++; if (running !== 1'b0) begin errors++; $display("FAIL rand_pause: running=%b want 0", running); end
            press(1'b1, 1'b0);
         end
      end
   endtask

   task automatic test_wrap;
      do_reset;
      mode_down = 1'b1;
      preset    = 16'h9998;
      press(1'b0, 1'b1);
      @(posedge clk); #1;
      checks++; if (seg !== seg_of(9998)) begin errors++; $display("FAIL wrap_load: got %h want %h", seg, seg_of(9998)); end
      mode_down = 1'b0;
      press(1'b1, 1'b0);
      repeat (11) @(posedge clk); #1;
      checks++; if (seg !== seg_of(9999)) begin errors++; $display("FAIL wrap_9999: got %h want %h", seg, seg_of(9999)); end
      repeat (10) @(posedge clk); #1;
      checks++; if (seg !== seg_of(0)) begin errors++; $display("FAIL wrap_0000: got %h want %h", seg, seg_of(0)); end
      checks++; if (running !== 1'b1 || time_done !== 1'b0) begin errors++; $display("FAIL wrap_flags: running=%b done=%b want 1/0", running, time_done); end
   endtask

   task automatic test_countdown(input int p);
      logic exp_done;
      do_reset;
      mode_down = 1'b1;
      preset    = 16'(p);
      press(1'b0, 1'b1);
      @(posedge clk); #1;
      checks++; if (seg !== seg_of(p)) begin errors++; $display("FAIL cd_load(%0d): got %h want %h", p, seg, seg_of(p)); end
      press(1'b1, 1'b0);
      @(posedge clk);
      for (int k = 1; k <= p; k++) begin
         repeat (10) @(posedge clk); #1;
         exp_done = (k == p);
         checks++; if (seg !== seg_of(p - k)) begin errors++; $display("FAIL cd_step(%0d/%0d): got %h want %h", k, p, seg, seg_of(p - k)); end
         checks++; if (time_done !== exp_done || running !== !exp_done) begin errors++; $display("FAIL cd_flags(%0d/%0d): done=%b running=%b want %b/%b", k, p, time_done, running, exp_done, !exp_done); end
      end
      press(1'b1, 1'b0);
      checks++; if (time_done !== 1'b1 || running !== 1'b0 || seg !== seg_of(0)) begin errors++; $display("FAIL cd_start_ignored: done=%b running=%b seg=%h", time_done, running, seg); end
      press(1'b0, 1'b1);
      checks++; if (time_done !== 1'b0) begin errors++; $display("FAIL cd_clear_done: got %b want 0", time_done); end
      @(posedge clk); #1;
      checks++; if (seg !== seg_of(p)) begin errors++; $display("FAIL cd_reload: got %h want %h", seg, seg_of(p)); end
   endtask

   task automatic test_preset_boundaries;
      logic [15:0] pr;
      do_reset;
      mode_down = 1'b1;
      preset    = 16'h0000;
      press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      repeat (9) @(posedge clk); #1;
      checks++; if (time_done !== 1'b0) begin errors++; $display("FAIL zero_early: done=%b want 0", time_done); end
      @(posedge clk); #1;
      checks++; if (time_done !== 1'b1) begin errors++; $display("FAIL zero_done: done=%b want 1", time_done); end
      @(posedge clk); #1;
      checks++; if (seg !== seg_of(0)) begin errors++; $display("FAIL zero_no_underflow: got %h want %h", seg, seg_of(0)); end
      for (int i = 0; i < 4; i++) begin
         pr = (i == 0) ? 16'h00A0 : 16'($urandom);
         preset = pr;
         press(1'b0, 1'b1);
         @(posedge clk); #1;
         checks++; if (seg !== seg_of(preset_value(pr))) begin errors++; $display("FAIL preset_sat(%h): got %h want %h", pr, seg, seg_of(preset_value(pr))); end
      end
   endtask

   task automatic test_priority;
      do_reset;
      mode_down = 1'b0;
      press(1'b1, 1'b0);
      repeat (15) @(posedge clk); #1;
      press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      checks++; if (running !== 1'b0 || time_done !== 1'b0) begin errors++; $display("FAIL prio_flags: running=%b done=%b want 0/0", running, time_done); end
      @(posedge clk); #1;
      checks++; if (seg !== seg_of(0)) begin errors++; $display("FAIL prio_cleared: got %h want %h", seg, seg_of(0)); end
      press(1'b1, 1'b0);
      repeat (10) @(posedge clk); #1;
      checks++; if (seg !== seg_of(0)) begin errors++; $display("FAIL prio_presc_cleared: got %h want %h", seg, seg_of(0)); end
      @(posedge clk); #1;
      checks++; if (seg !== seg_of(1)) begin errors++; $display("FAIL prio_first_tick: got %h want %h", seg, seg_of(1)); end
   endtask

   task automatic test_rst_midrun;
      int r;
      do_reset;
      mode_down = 1'b0;
      r = $urandom_range(0, 8);
      press(1'b1, 1'b0);
      repeat (421 + r) @(posedge clk); #1;
      checks++; if (seg !== seg_of(42)) begin errors++; $display("FAIL rst_pre_42: got %h want %h", seg, seg_of(42)); end
      rst = 1'b1;
      #1;
      checks++; if (seg !== seg_of(0) || running !== 1'b0) begin errors++; $display("FAIL rst_immediate: seg=%h running=%b want %h/0", seg, running, seg_of(0)); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (15) @(posedge clk); #1;
      checks++; if (seg !== seg_of(0) || running !== 1'b0) begin errors++; $display("FAIL rst_idle_after: seg=%h running=%b", seg, running); end
   endtask

`ifdef BCD_TIMER_LAP_EN
   task automatic test_lap;
      do_reset;
      mode_down = 1'b0;
      press(1'b1, 1'b0);
      repeat (93) @(posedge clk); #1;
      press(1'b0, 1'b1);
      checks++; if (seg !== seg_of(10)) begin errors++; $display("FAIL lap_capture: got %h want %h", seg, seg_of(10)); end
      repeat (50) @(posedge clk); #1;
      checks++; if (seg !== seg_of(10) || running !== 1'b1) begin errors++; $display("FAIL lap_frozen: seg=%h running=%b want %h/1", seg, running, seg_of(10)); end
      press(1'b0, 1'b1);
      @(posedge clk); #1;
      checks++; if (seg !== seg_of(15)) begin errors++; $display("FAIL lap_release: got %h want %h", seg, seg_of(15)); end
      @(posedge clk); #1;
      checks++; if (seg !== seg_of(16)) begin errors++; $display("FAIL lap_tracking: got %h want %h", seg, seg_of(16)); end
   endtask
`else
   task automatic test_clear_ignored_in_run;
      do_reset;
      mode_down = 1'b0;
      press(1'b1, 1'b0);
      repeat (15) @(posedge clk); #1;
      press(1'b0, 1'b1);
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_clear_ignored: running=%b want 1", running); end
      repeat (8) @(posedge clk); #1;
      checks++; if (seg !== seg_of(3)) begin errors++; $display("FAIL run_clear_count: got %h want %h", seg, seg_of(3)); end
   endtask
`endif

   initial begin
      test_reset;
      test_debounce;
      test_count_up_pause;
      test_random_runs;
      test_wrap;
      test_countdown(3);
      test_countdown($urandom_range(1, 9));
      test_preset_boundaries;
      test_priority;
      test_rst_midrun;
`ifdef BCD_TIMER_LAP_EN
      test_lap;
`else
      test_clear_ignored_in_run;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
